// File: rtl/cross_prod_arbiter.sv
// Round-robin arbiter sharing one 2-stage signed cross-product pipeline between NREQ requesters.
// Optional CP_LOCK_EN adds a per-requester lock input that holds priority on the granted requester.
module cross_prod_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned W    = 10,
    parameter int unsigned ID_W = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*2*W-1:0]    op_a,
    input  logic [NREQ*2*W-1:0]    op_b,
    input  logic [NREQ*2*W-1:0]    op_ref,
`ifdef CP_LOCK_EN
    input  logic [NREQ-1:0]        lock,
`endif
    output logic [NREQ-1:0]        gnt,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_pos,
    output logic                   rsp_zero,
    output logic                   busy
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned PT_W  = 2 * W;
    localparam int unsigned CP_W  = 2 * W + 3;
    localparam logic [PTR_W:0] NREQ_L = (PTR_W + 1)'(NREQ);

    logic [PT_W-1:0] a_arr   [NREQ];
    logic [PT_W-1:0] b_arr   [NREQ];
    logic [PT_W-1:0] ref_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_split
        assign a_arr[i]   = op_a[i*PT_W +: PT_W];
        assign b_arr[i]   = op_b[i*PT_W +: PT_W];
        assign ref_arr[i] = op_ref[i*PT_W +: PT_W];
    end

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] ptr_nxt;
    logic [PTR_W:0]   cand_sum;
    logic [PTR_W-1:0] cand;
    logic [PTR_W:0]   inc_sum;
    logic             gnt_any;
    logic [PT_W-1:0]  sel_a;
    logic [PT_W-1:0]  sel_b;
    logic [PT_W-1:0]  sel_ref;

    // First requesting agent at or above rr_ptr, with wrap.
    always_comb begin
        gnt      = '0;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand_sum = '0;
        cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_sum = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
            if (cand_sum >= NREQ_L) begin
                cand_sum = cand_sum - NREQ_L;
            end
            cand = PTR_W'(cand_sum);
            if (!gnt_any && req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_any && !reset) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // Priority pointer advances past the winner unless it asserted lock.
    always_comb begin
        inc_sum = {1'b0, gnt_idx} + (PTR_W + 1)'(1);
        if (inc_sum >= NREQ_L) begin
            inc_sum = '0;
        end
        ptr_nxt = PTR_W'(inc_sum);
`ifdef CP_LOCK_EN
        if (lock[gnt_idx]) begin
            ptr_nxt = gnt_idx;
        end
`endif
    end

    always_comb begin
        sel_a   = a_arr[gnt_idx];
        sel_b   = b_arr[gnt_idx];
        sel_ref = ref_arr[gnt_idx];
    end

    logic                s1_valid;
    logic [ID_W-1:0]     s1_id;
    logic signed [W:0]   s1_dax;
    logic signed [W:0]   s1_day;
    logic signed [W:0]   s1_dbx;
    logic signed [W:0]   s1_dby;
    logic signed [CP_W-1:0] cp;

    // Full-width product: (W+1)x(W+1) products plus one bit for the subtraction.
    always_comb begin
        cp = CP_W'(s1_dax) * CP_W'(s1_dby) - CP_W'(s1_dbx) * CP_W'(s1_day);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            s1_valid  <= 1'b0;
            s1_id     <= '0;
            s1_dax    <= '0;
            s1_day    <= '0;
            s1_dbx    <= '0;
            s1_dby    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_pos   <= 1'b0;
            rsp_zero  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            s1_valid  <= gnt_any;
            rsp_valid <= s1_valid;
            busy      <= gnt_any | s1_valid;
            if (gnt_any) begin
                rr_ptr <= ptr_nxt;
                s1_id  <= ID_W'(gnt_idx);
                s1_dax <= (W + 1)'(sel_a[PT_W-1:W]) - (W + 1)'(sel_ref[PT_W-1:W]);
                s1_day <= (W + 1)'(sel_a[W-1:0])    - (W + 1)'(sel_ref[W-1:0]);
                s1_dbx <= (W + 1)'(sel_b[PT_W-1:W]) - (W + 1)'(sel_ref[PT_W-1:W]);
                s1_dby <= (W + 1)'(sel_b[W-1:0])    - (W + 1)'(sel_ref[W-1:0]);
            end
            if (s1_valid) begin
                rsp_id   <= s1_id;
                rsp_pos  <= !cp[CP_W-1] && (cp != '0);
                rsp_zero <= (cp == '0);
            end
        end
    end

endmodule

// File: tb/tb_cross_prod_arbiter.sv
// Directed-vector bench for cross_prod_arbiter (NREQ=2, W=10); lock scenario adapts to CP_LOCK_EN.
module tb_cross_prod_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned W    = 10;
    localparam int unsigned ID_W = 1;
    localparam int unsigned PT_W = 2 * W;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*PT_W-1:0]  op_a;
    logic [NREQ*PT_W-1:0]  op_b;
    logic [NREQ*PT_W-1:0]  op_ref;
`ifdef CP_LOCK_EN
    logic [NREQ-1:0]       lock;
`endif
    logic [NREQ-1:0]       gnt;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic                  rsp_pos;
    logic                  rsp_zero;
    logic                  busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cross_prod_arbiter #(.NREQ(NREQ), .W(W), .ID_W(ID_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_ref    (op_ref),
`ifdef CP_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_pos   (rsp_pos),
        .rsp_zero  (rsp_zero),
        .busy      (busy)
    );

    function automatic logic [PT_W-1:0] pt(input int x, input int y);
        return {W'(x), W'(y)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 2'b11;
        #1;
        vectors++;
        if (gnt !== 2'b00) begin miscompares++; $display("FAIL reset_gnt got=%b want=00", gnt); end
        vectors++;
        if ({rsp_valid, rsp_id, rsp_pos, rsp_zero, busy} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%b want=00000", {rsp_valid, rsp_id, rsp_pos, rsp_zero, busy});
        end
        @(negedge clk);
        req   = '0;
        reset = 1'b0;
    endtask

    // One op from requester rq; checks grant, latency and flags.
    task automatic test_single(input string name, input int rq,
                               input int ax, input int ay, input int bx, input int by,
                               input int rx, input int ry, input logic exp_pos, input logic exp_zero);
        logic [NREQ-1:0] exp_gnt;
        exp_gnt = '0;
        exp_gnt[rq] = 1'b1;
        @(negedge clk);
        op_a = '0; op_b = '0; op_ref = '0;
        op_a[rq*PT_W +: PT_W]   = pt(ax, ay);
        op_b[rq*PT_W +: PT_W]   = pt(bx, by);
        op_ref[rq*PT_W +: PT_W] = pt(rx, ry);
        req = exp_gnt;
        #1;
        vectors++;
        if (gnt !== exp_gnt) begin miscompares++; $display("FAIL %s_gnt got=%b want=%b", name, gnt, exp_gnt); end
        @(negedge clk);
        req = '0;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_n1 got valid=%b busy=%b want valid=0 busy=1", name, rsp_valid, busy);
        end
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(rq) || rsp_pos !== exp_pos || rsp_zero !== exp_zero) begin
            miscompares++;
            $display("FAIL %s_rsp got v=%b id=%0d pos=%b zero=%b want v=1 id=%0d pos=%b zero=%b",
                     name, rsp_valid, rsp_id, rsp_pos, rsp_zero, rq, exp_pos, exp_zero);
        end
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_drain got valid=%b busy=%b want 0 0", name, rsp_valid, busy);
        end
    endtask

    // req=11 for 6 cycles: alternating grants, 6 back-to-back responses.
    task automatic test_back_to_back();
        logic [NREQ-1:0] eg;
        logic            ev;
        do_reset();
        op_a   = {pt(0, 4), pt(3, 0)};
        op_b   = {pt(3, 0), pt(0, 4)};
        op_ref = '0;
        for (int c = 0; c < 9; c++) begin
            req = (c < 6) ? 2'b11 : 2'b00;
            #1;
            eg = (c >= 6) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
            ev = (c >= 2 && c < 8);
            vectors++;
            if (gnt !== eg) begin miscompares++; $display("FAIL rr_gnt c=%0d got=%b want=%b", c, gnt, eg); end
            vectors++;
            if (rsp_valid !== ev) begin miscompares++; $display("FAIL rr_valid c=%0d got=%b want=%b", c, rsp_valid, ev); end
            if (ev) begin
                vectors++;
                if (rsp_id !== ID_W'((c - 2) % 2) || rsp_pos !== ((c - 2) % 2 == 0)) begin
                    miscompares++;
                    $display("FAIL rr_rsp c=%0d got id=%0d pos=%b want id=%0d pos=%b",
                             c, rsp_id, rsp_pos, (c - 2) % 2, ((c - 2) % 2 == 0));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        op_a   = {pt(3, 0), pt(3, 0)};
        op_b   = {pt(0, 4), pt(0, 4)};
        op_ref = '0;
        req    = 2'b11;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || gnt !== 2'b00) begin
            miscompares++;
            $display("FAIL midrst_clear got valid=%b busy=%b gnt=%b want 0 0 00", rsp_valid, busy, gnt);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if (gnt !== 2'b01) begin miscompares++; $display("FAIL midrst_first_gnt got=%b want=01", gnt); end
        @(negedge clk);
        req = '0;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_stale got=%b want=0", rsp_valid); end
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_pos !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_rsp got v=%b id=%0d pos=%b want v=1 id=0 pos=1", rsp_valid, rsp_id, rsp_pos);
        end
        @(negedge clk);
    endtask

    // Lock held by requester 0 for three grants, then released.
    task automatic test_lock();
        logic [NREQ-1:0] exp_seq [6];
`ifdef CP_LOCK_EN
        exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
`else
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
        do_reset();
        for (int c = 0; c < 6; c++) begin
            req = 2'b11;
`ifdef CP_LOCK_EN
            lock = (c < 3) ? 2'b01 : 2'b00;
`endif
            #1;
            vectors++;
            if (gnt !== exp_seq[c]) begin
                miscompares++;
                $display("FAIL lock_gnt c=%0d got=%b want=%b", c, gnt, exp_seq[c]);
            end
            @(negedge clk);
        end
        req = '0;
`ifdef CP_LOCK_EN
        lock = '0;
`endif
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        req    = '0;
        op_a   = '0;
        op_b   = '0;
        op_ref = '0;
`ifdef CP_LOCK_EN
        lock   = '0;
`endif
        test_reset();
        test_single("cp_pos12",    0, 3, 0, 0, 4, 0, 0, 1'b1, 1'b0);
        test_single("cp_neg12",    0, 0, 4, 3, 0, 0, 0, 1'b0, 1'b0);
        test_single("cp_zero",     0, 2, 2, 4, 4, 0, 0, 1'b0, 1'b1);
        test_single("cp_max_pos",  0, 1023, 0, 0, 1023, 0, 0, 1'b1, 1'b0);
        test_single("cp_max_neg",  0, 1023, 0, 0, 1023, 1023, 1023, 1'b0, 1'b0);
        test_single("cp_req1_ref", 1, 5, 7, 2, 9, 4, 3, 1'b1, 1'b0);
        test_back_to_back();
        test_reset_mid_op();
        test_lock();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
